instr_mem_param: RTL and testbench
==================================

Name: instr_mem_param

Overview:
Parametrised, byte-addressed instruction memory for the ARM pipeline fetch stage. It replaces the fixed 32-bit asynchronous array with a clocked block that has:
- configurable word count;
- a one-cycle registered read with a request/grant/valid handshake and stall hold;
- a byte-enabled program-load write port;
- a self-initialising NOP fill after reset;
- alignment and range fault reporting.

Parameters:
WORD_W, 32, instruction word width in bits (multiple of 8).
DEPTH_WORDS, 256, number of stored words (power of 2).
ADDR_W, 32, byte-address width of both ports.
NOP_WORD, 32'hE000_0000, fill value after reset and the data returned on a fault (AND R0,R0,R0 with cond AL).

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous, active-low reset; asserted when 0, sampled on the clk rising edge.
rd_req  input  1  fetch request.
rd_addr  input  ADDR_W  fetch byte address.
rd_gnt  output  1  request accepted this cycle.
rd_stall  input  1  consumer cannot take rd_data this cycle.
rd_valid  output  1  rd_data/rd_fault are valid.
rd_data  output  WORD_W  fetched instruction.
rd_fault  output  2  bit0 = misaligned, bit1 = out of range.
wr_en  input  1  program-load write.
wr_addr  input  ADDR_W  write byte address (word-aligned; bits [1:0] ignored).
wr_be  input  WORD_W/8  byte enables; wr_be[WORD_W/8-1] selects bits [WORD_W-1:WORD_W-8].
wr_data  input  WORD_W  write data.
init_busy  output  1  NOP fill in progress.

Behaviour:
- Byte ordering is big-endian within a word.
  - Byte address 4k+0 holds bits [31:24].
  - Byte address 4k+3 holds bits [7:0].
  - Word index = addr[ADDR_W-1:2].
- Reset (rst==0 at an edge):
  - state <= INIT, fill pointer <= 0.
  - rd_valid <= 0, rd_data <= NOP_WORD, rd_fault <= 0, init_busy <= 1.
  - Reset mid-fill or mid-read aborts the current operation and restarts the fill from word 0.
  - Any pending rd_valid is dropped.
- INIT state:
  - Each cycle writes NOP_WORD to word[ptr] and increments ptr.
  - After writing word DEPTH_WORDS-1, moves to RUN. init_busy falls on the same edge.
  - Fill takes exactly DEPTH_WORDS cycles after reset is released.
  - In INIT: rd_gnt = 0, and wr_en is ignored (dropped, not queued).
- RUN state:
  - rd_gnt = rd_req & ~(rd_valid & rd_stall), combinational.
  - On grant, rd_data/rd_fault register the addressed word on the next edge, and rd_valid <= 1. Latency is 1 cycle.
  - With no grant and no stall, rd_valid <= 0.
  - With rd_valid & rd_stall, rd_data, rd_fault and rd_valid hold unchanged and no new request is granted.
  - Back-to-back grants give one word per cycle.
- Faults:
  - rd_addr[1:0] != 0 sets rd_fault[0].
  - Word index >= DEPTH_WORDS sets rd_fault[1].
  - Both bits may be set together.
  - Any fault returns rd_data = NOP_WORD; the array is not read.
- Writes (RUN only):
  - On wr_en, each byte lane with its wr_be bit set is updated on the edge.
  - An out-of-range wr_addr is silently dropped.
  - wr_be == 0 is a no-op.
- Simultaneous read and write to the same word in one cycle is read-first: rd_data returns the pre-write contents, and the new value is visible from the next request.
- The memory array is never cleared by anything other than the INIT fill.

Decomposition:
- Shared package: the ARM NOP encoding constant and the rd_fault bit positions (FAULT_MISALIGN = 0, FAULT_RANGE = 1). These go alongside the existing INSTRUCTION_LEN and INSTRUCTION_MEM_SIZE defines.
- One sub-module, imem_byte_ram: a DEPTH_WORDS x WORD_W array with a per-byte write enable and a synchronous read-first read.
- The FSM, handshake and fault logic stay in the top level.

Test Plan:
- Release rst at cycle 0, hold rd_req = 1 at address 0 → rd_gnt = 0 for 256 cycles; init_busy falls at cycle 256; first rd_valid returns 32'hE000_0000 with fault 0.
- Load 32'hE3A00014 at address 4 with wr_be = 4'hF, then read 4, 8, 4 on consecutive cycles → rd_valid on 3 consecutive cycles with data E3A00014, E0000000, E3A00014.
- Write wr_be = 4'b1000, data 32'hAA000000 to address 8, then read 8 → 32'hAA000000. Then write wr_be = 4'b0001, data 32'h000000BB to address 8 in the same cycle as a read of 8 → the read returns AA000000; the next read returns AA0000BB.
- Read address 6, then address 1024 (word 256) → rd_fault = 2'b01 then 2'b10, both with rd_data = E0000000; a write to 1024 leaves words 0–255 unchanged.
- Assert rd_stall for 3 cycles while rd_valid = 1 and rd_req is held at a new address → rd_data is held and rd_gnt = 0 throughout; the new word arrives 1 cycle after rd_stall falls.
- Pull rst low at fill cycle 100 and again mid-stream in RUN → init_busy restarts; the next valid data appears exactly 256 cycles plus 1 cycle of latency after release; all previously loaded words read back as NOP.

Source files
------------

// File: rtl/instr_mem_param_pkg.sv
// Shared instruction-memory constants: ARM NOP encoding, fault bit positions, FSM states.
// Latency: n/a (constants only).
// Backpressure: n/a.
package instr_mem_param_pkg;

  // Legacy fixed-memory geometry, kept for existing users.
  localparam int INSTRUCTION_LEN      = 32;
  localparam int INSTRUCTION_MEM_SIZE = 256;

  // AND R0,R0,R0 with cond AL: a harmless fetch result for empty or faulting slots.
  localparam logic [31:0] ARM_NOP = 32'hE000_0000;

  // rd_fault bit positions.
  localparam int FAULT_MISALIGN = 0;
  localparam int FAULT_RANGE    = 1;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } imem_state_t;

endpackage

// File: rtl/imem_byte_ram.sv
// Word-organised RAM with per-byte write enables and a synchronous read-first read.
// Latency: 1 cycle read; rdata holds its value while re is low.
// Backpressure: none; the caller holds re low to keep rdata stable.
// Ports: clk; we/waddr/wbe/wdata write port (wbe[NB-1] -> bits [WORD_W-1:WORD_W-8]);
//        re/raddr read port; rdata registered read data.
module imem_byte_ram #(
  parameter int WORD_W      = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic                clk,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [WORD_W/8-1:0] wbe,
  input  logic [WORD_W-1:0]   wdata,
  input  logic                re,
  input  logic [AW-1:0]       raddr,
  output logic [WORD_W-1:0]   rdata
);

  localparam int NB = WORD_W / 8;

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  // Non-blocking read and write on the same edge gives read-first behaviour.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[raddr];
    end
    for (int b = 0; b < NB; b++) begin
      if (we && wbe[b]) begin
        mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/instr_mem_param.sv
// Byte-addressed fetch-stage instruction memory with NOP self-fill, program-load port and fault flags.
// Latency: 1 cycle from rd_gnt to rd_valid; fill occupies DEPTH_WORDS cycles after reset.
// Backpressure: rd_valid & rd_stall holds rd_data/rd_fault/rd_valid and withholds rd_gnt.
// Ports: clk, rst (sync, active low); rd_req/rd_addr/rd_gnt fetch request;
//        rd_stall/rd_valid/rd_data/rd_fault fetch response; wr_en/wr_addr/wr_be/wr_data
//        program load; init_busy high while the NOP fill runs.
module instr_mem_param
  import instr_mem_param_pkg::*;
#(
  parameter int                WORD_W      = 32,
  parameter int                DEPTH_WORDS = 256,
  parameter int                ADDR_W      = 32,
  parameter logic [WORD_W-1:0] NOP_WORD    = WORD_W'(ARM_NOP)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rd_req,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic                rd_gnt,
  input  logic                rd_stall,
  output logic                rd_valid,
  output logic [WORD_W-1:0]   rd_data,
  output logic [1:0]          rd_fault,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [WORD_W/8-1:0] wr_be,
  input  logic [WORD_W-1:0]   wr_data,
  output logic                init_busy
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int NB = WORD_W / 8;

  imem_state_t       state;
  logic [AW-1:0]     fill_ptr;
  logic              use_ram_q;   // rd_data comes from the RAM rather than NOP_WORD
  logic [1:0]        rd_fault_c;
  logic              wr_in_range;
  logic              ram_we;
  logic [AW-1:0]     ram_waddr;
  logic [NB-1:0]     ram_wbe;
  logic [WORD_W-1:0] ram_wdata;
  logic              ram_re;
  logic [WORD_W-1:0] ram_rdata;

  // Low address bits of program-load writes are ignored by design.
  logic unused_wr_lsb;
  assign unused_wr_lsb = &{1'b0, wr_addr[1:0]};

  // Any set bit above the word-index field means the word index is >= DEPTH_WORDS.
  assign rd_fault_c[FAULT_MISALIGN] = (rd_addr[1:0] != 2'b00);
  assign rd_fault_c[FAULT_RANGE]    = ((rd_addr >> (AW + 2)) != '0);
  assign wr_in_range                = ((wr_addr >> (AW + 2)) == '0);

  assign rd_gnt = (state == ST_RUN) && rd_req && !(rd_valid && rd_stall);

  // The RAM write port is shared between the NOP fill and program loads; nothing
  // writes while reset is asserted.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = wr_addr[AW+1:2];
    ram_wbe   = wr_be;
    ram_wdata = wr_data;
    if (state == ST_INIT) begin
      ram_we    = rst;
      ram_waddr = fill_ptr;
      ram_wbe   = '1;
      ram_wdata = NOP_WORD;
    end else begin
      ram_we    = rst && wr_en && wr_in_range;
    end
  end

  // Faulting fetches never touch the array, so its output register keeps the last good word.
  assign ram_re = rd_gnt && (rd_fault_c == 2'b00);

  imem_byte_ram #(
    .WORD_W      (WORD_W),
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wbe   (ram_wbe),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (rd_addr[AW+1:2]),
    .rdata (ram_rdata)
  );

  assign rd_data = use_ram_q ? ram_rdata : NOP_WORD;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_INIT;
      fill_ptr  <= '0;
      init_busy <= 1'b1;
      rd_valid  <= 1'b0;
      rd_fault  <= 2'b00;
      use_ram_q <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          fill_ptr <= fill_ptr + 1'b1;
          if (fill_ptr == AW'(DEPTH_WORDS - 1)) begin
            state     <= ST_RUN;
            init_busy <= 1'b0;
          end
        end
        default: begin
          if (rd_gnt) begin
            rd_valid  <= 1'b1;
            rd_fault  <= rd_fault_c;
            use_ram_q <= (rd_fault_c == 2'b00);
          end else if (!(rd_valid && rd_stall)) begin
            rd_valid <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_param.sv
module tb_instr_mem_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic        rd_gnt;
  logic        rd_stall;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic [1:0]  rd_fault;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [3:0]  wr_be;
  logic [31:0] wr_data;
  logic        init_busy;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] NOP = 32'hE000_0000;

  always #5 clk = ~clk;

  instr_mem_param dut (
    .clk       (clk),
    .rst       (rst),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_gnt    (rd_gnt),
    .rd_stall  (rd_stall),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .rd_fault  (rd_fault),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_be     (wr_be),
    .wr_data   (wr_data),
    .init_busy (init_busy)
  );

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int bad;
    rst = 1'b0; rd_req = 1'b0; rd_addr = '0; rd_stall = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_be = '0; wr_data = '0;
    tick(); tick();
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== NOP || rd_fault !== 2'b00 || init_busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: valid=%b data=%h fault=%b busy=%b, want 0 %h 00 1",
               rd_valid, rd_data, rd_fault, init_busy, NOP);
    end
    rst = 1'b1; rd_req = 1'b1; rd_addr = 32'd0;
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (rd_gnt !== 1'b0 || init_busy !== 1'b1) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL fill_gnt_busy: %0d cycles with gnt=1 or busy=0, want 0", bad);
    end
    checks++;
    if (init_busy !== 1'b0 || rd_gnt !== 1'b1) begin
      errors++;
      $display("FAIL fill_end: busy=%b gnt=%b after 256 cycles, want 0 1", init_busy, rd_gnt);
    end
    tick();
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== NOP || rd_fault !== 2'b00) begin
      errors++;
      $display("FAIL first_read: valid=%b data=%h fault=%b, want 1 %h 00",
               rd_valid, rd_data, rd_fault, NOP);
    end
    rd_req = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [3];
    logic [31:0] exp   [3];
    addrs[0] = 32'd4; addrs[1] = 32'd8; addrs[2] = 32'd4;
    exp[0] = 32'hE3A0_0014; exp[1] = NOP; exp[2] = 32'hE3A0_0014;
    wr_en = 1'b1; wr_addr = 32'd4; wr_be = 4'hF; wr_data = 32'hE3A0_0014;
    tick();
    wr_en = 1'b0;
    rd_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rd_addr = addrs[i];
      tick();
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp[i] || rd_fault !== 2'b00) begin
        errors++;
        $display("FAIL b2b_read%0d: valid=%b data=%h fault=%b, want 1 %h 00",
                 i, rd_valid, rd_data, rd_fault, exp[i]);
      end
    end
    rd_req = 1'b0;
    tick();
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_valid: valid=%b, want 0", rd_valid);
    end
  endtask

  task automatic test_byte_enable();
    wr_en = 1'b1; wr_addr = 32'd8; wr_be = 4'b1000; wr_data = 32'hAA00_0000;
    tick();
    wr_en = 1'b0; rd_req = 1'b1; rd_addr = 32'd8;
    tick();
    checks++;
    if (rd_data !== 32'hAA00_0000) begin
      errors++;
      $display("FAIL be_top_lane: data=%h, want AA000000", rd_data);
    end
    wr_en = 1'b1; wr_addr = 32'd8; wr_be = 4'b0001; wr_data = 32'h0000_00BB;
    tick();
    wr_en = 1'b0;
    checks++;
    if (rd_data !== 32'hAA00_0000) begin
      errors++;
      $display("FAIL read_first: data=%h, want AA000000", rd_data);
    end
    tick();
    checks++;
    if (rd_data !== 32'hAA00_00BB) begin
      errors++;
      $display("FAIL be_low_lane: data=%h, want AA0000BB", rd_data);
    end
    rd_req = 1'b0;
    tick();
  endtask

  task automatic test_faults();
    logic [31:0] addrs [3];
    logic [1:0]  expf  [3];
    addrs[0] = 32'd6;    expf[0] = 2'b01;
    addrs[1] = 32'd1024; expf[1] = 2'b10;
    addrs[2] = 32'd1027; expf[2] = 2'b11;
    rd_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rd_addr = addrs[i];
      tick();
      checks++;
      if (rd_valid !== 1'b1 || rd_fault !== expf[i] || rd_data !== NOP) begin
        errors++;
        $display("FAIL fault%0d: valid=%b fault=%b data=%h, want 1 %b %h",
                 i, rd_valid, rd_fault, rd_data, expf[i], NOP);
      end
    end
    rd_req = 1'b0;
    // Out-of-range writes would alias words 0 and 1 if not dropped.
    wr_en = 1'b1; wr_addr = 32'd1024; wr_be = 4'hF; wr_data = 32'h1234_5678;
    tick();
    wr_addr = 32'd1028;
    tick();
    wr_en = 1'b0; rd_req = 1'b1; rd_addr = 32'd0;
    tick();
    checks++;
    if (rd_data !== NOP || rd_fault !== 2'b00) begin
      errors++;
      $display("FAIL oor_write_w0: data=%h fault=%b, want %h 00", rd_data, rd_fault, NOP);
    end
    rd_addr = 32'd4;
    tick();
    checks++;
    if (rd_data !== 32'hE3A0_0014) begin
      errors++;
      $display("FAIL oor_write_w1: data=%h, want E3A00014", rd_data);
    end
    rd_req = 1'b0;
    tick();
  endtask

  task automatic test_stall();
    int bad;
    rd_req = 1'b1; rd_addr = 32'd4;
    tick();
    rd_stall = 1'b1; rd_addr = 32'd8;
    #1;
    checks++;
    if (rd_gnt !== 1'b0) begin
      errors++;
      $display("FAIL stall_gnt: gnt=%b, want 0", rd_gnt);
    end
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (rd_valid !== 1'b1 || rd_data !== 32'hE3A0_0014 || rd_gnt !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL stall_hold: %0d bad cycles, want 0", bad);
    end
    rd_stall = 1'b0;
    #1;
    checks++;
    if (rd_gnt !== 1'b1) begin
      errors++;
      $display("FAIL unstall_gnt: gnt=%b, want 1", rd_gnt);
    end
    tick();
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 32'hAA00_00BB) begin
      errors++;
      $display("FAIL unstall_data: valid=%b data=%h, want 1 AA0000BB", rd_valid, rd_data);
    end
    rd_req = 1'b0;
    tick();
  endtask

  // Count edges from reset release to the first rd_valid; expect 256 fill + 1 latency.
  task automatic wait_valid(input string name, input logic [31:0] addr);
    int n;
    rst = 1'b1; rd_req = 1'b1; rd_addr = addr;
    n = 0;
    while (rd_valid !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    checks++;
    if (n != 257) begin
      errors++;
      $display("FAIL %s_latency: %0d cycles, want 257", name, n);
    end
    checks++;
    if (rd_data !== NOP) begin
      errors++;
      $display("FAIL %s_data: data=%h, want %h", name, rd_data, NOP);
    end
  endtask

  task automatic test_reset_restart();
    rd_req = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 100; i++) tick();
    rst = 1'b0;
    tick();
    checks++;
    if (init_busy !== 1'b1 || rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL midfill_reset: busy=%b valid=%b, want 1 0", init_busy, rd_valid);
    end
    wait_valid("midfill", 32'd4);
    rd_addr = 32'd8;
    tick();
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== NOP || init_busy !== 1'b1) begin
      errors++;
      $display("FAIL run_reset: valid=%b data=%h busy=%b, want 0 %h 1",
               rd_valid, rd_data, init_busy, NOP);
    end
    wait_valid("runreset", 32'd8);
    rd_req = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_byte_enable();
    test_faults();
    test_stall();
    test_reset_restart();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
